// File: rtl/ifm_pkg.sv
// Shared definitions for the multi-channel receive output arbiter.
package ifm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2,
    S_EOF  = 2'd3
  } ifm_state_t;

  // Default width of each per-channel frame counter.
  localparam int C_CNTW_DEF = 32;

  // The EOF flag sits directly above the payload, at bit index C_DW of a word.
  function automatic int eof_bit(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/ifm_rr_arb.sv
// Combinational round-robin arbiter: picks the lowest requesting index at or
// after ptr, wrapping. The pointer register lives in the parent.
module ifm_rr_arb
  import ifm_pkg::*;
#(
  parameter int C_NCH = 4,
  parameter int C_CHW = 2
) (
  input  logic [C_NCH-1:0] req,
  input  logic [C_CHW-1:0] ptr,
  input  logic             gnt_en,
  output logic [C_CHW-1:0] gnt_idx,
  output logic             gnt_valid
);

  int               idx;
  logic [C_CHW-1:0] sel_k;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    sel_k     = '0;
    for (int k = C_NCH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= C_NCH) idx = idx - C_NCH;
      sel_k = C_CHW'(idx);
      if (gnt_en && req[sel_k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel_k;
      end
    end
  end

endmodule

// File: rtl/ifm_out_arb.sv
// Round-robin frame arbiter: moves whole frames from C_NCH show-ahead data
// FIFOs into one shared good-frame FIFO, discards frames flagged bad, and
// keeps saturating per-channel good/drop frame counters.
module ifm_out_arb
  import ifm_pkg::*;
#(
  parameter int C_DW   = 72,
  parameter int C_NCH  = 4,
  parameter int C_CHW  = 2,
  parameter int C_CNTW = C_CNTW_DEF
) (
  input  logic                       sys_clk,
  input  logic                       rx_reset,
  input  logic [C_NCH*(C_DW+1)-1:0]  data_fifo_rdata,
  output logic [C_NCH-1:0]           data_fifo_rden,
  input  logic [C_NCH-1:0]           info_fifo_rdata,
  input  logic [C_NCH-1:0]           info_fifo_empty,
  output logic [C_NCH-1:0]           info_fifo_rden,
  output logic [C_DW:0]              good_fifo_wdata,
  output logic [C_CHW-1:0]           good_fifo_wchan,
  output logic                       good_fifo_wren,
  input  logic                       good_fifo_afull,
  input  logic                       cnt_clr,
  output logic [C_NCH*C_CNTW-1:0]    good_cnt,
  output logic [C_NCH*C_CNTW-1:0]    drop_cnt
);

  localparam int C_WW  = C_DW + 1;
  localparam int EOF_B = eof_bit(C_DW);

  ifm_state_t       state;
  logic [C_CHW-1:0] ptr;
  logic [C_CHW-1:0] cur;
  logic             verdict_q;

  logic [C_CHW-1:0] gnt_idx;
  logic             gnt_valid;
  logic             gnt_en;
  logic [C_CHW-1:0] sel;
  logic             verdict;
  logic             pop;
  logic             pop_eof;
  logic             wr;
  logic [C_WW-1:0]  pop_word;
  logic [C_NCH-1:0] rden;

  logic [C_WW-1:0]  wdata_p1;
  logic [C_CHW-1:0] wchan_p1;
  logic             vld_p1;
  logic [C_NCH-1:0] info_rden_p1;

  function automatic logic [C_CHW-1:0] next_ptr(input logic [C_CHW-1:0] i);
    if (int'(i) == C_NCH - 1) return '0;
    return i + 1'b1;
  endfunction

  function automatic logic [C_CNTW-1:0] sat_inc(input logic [C_CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign gnt_en = (state == S_IDLE) && !good_fifo_afull;

  ifm_rr_arb #(
    .C_NCH (C_NCH),
    .C_CHW (C_CHW)
  ) u_arb (
    .req       (~info_fifo_empty),
    .ptr       (ptr),
    .gnt_en    (gnt_en),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Pop decision: in IDLE the arbiter picks the channel and supplies a fresh
  // verdict; afterwards the latched channel and verdict are used.
  always_comb begin
    sel     = (state == S_IDLE) ? gnt_idx : cur;
    verdict = (state == S_IDLE) ? info_fifo_rdata[gnt_idx] : verdict_q;
    case (state)
      S_IDLE:  pop = gnt_valid;
      S_FWD:   pop = !good_fifo_afull;
      S_DROP:  pop = 1'b1;
      default: pop = 1'b0;
    endcase
    rden = '0;
    if (pop) rden[sel] = 1'b1;
    pop_word = data_fifo_rdata[int'(sel)*C_WW +: C_WW];
    pop_eof  = pop_word[EOF_B];
    wr       = pop && verdict;
  end

  assign data_fifo_rden = rden;

  // Frame FSM plus the registered write/info-pop outputs.
  always_ff @(posedge sys_clk or posedge rx_reset) begin
    if (rx_reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      cur          <= '0;
      verdict_q    <= 1'b0;
      wdata_p1     <= '0;
      wchan_p1     <= '0;
      vld_p1       <= 1'b0;
      info_rden_p1 <= '0;
    end else begin
      // stage p0 -> p1: popped word becomes the output-FIFO write
      vld_p1 <= wr;
      if (wr) begin
        wdata_p1 <= pop_word;
        wchan_p1 <= sel;
      end
      info_rden_p1 <= '0;
      if (pop && pop_eof) info_rden_p1[sel] <= 1'b1;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            cur       <= gnt_idx;
            ptr       <= next_ptr(gnt_idx);
            verdict_q <= verdict;
            if (pop_eof)      state <= S_EOF;
            else if (verdict) state <= S_FWD;
            else              state <= S_DROP;
          end
        end
        S_FWD:   if (pop && pop_eof) state <= S_EOF;
        S_DROP:  if (pop_eof) state <= S_EOF;
        S_EOF:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign good_fifo_wdata = wdata_p1;
  assign good_fifo_wchan = wchan_p1;
  assign good_fifo_wren  = vld_p1;
  assign info_fifo_rden  = info_rden_p1;

  for (genvar g = 0; g < C_NCH; g++) begin : gen_cnt
    logic [C_CNTW-1:0] good_q;
    logic [C_CNTW-1:0] drop_q;
    logic              done;

    assign done = pop && pop_eof && (sel == C_CHW'(g));

    // Saturating frame counters; a same-cycle clear wins over an increment.
    always_ff @(posedge sys_clk or posedge rx_reset) begin
      if (rx_reset) begin
        good_q <= '0;
        drop_q <= '0;
      end else if (cnt_clr) begin
        good_q <= '0;
        drop_q <= '0;
      end else if (done) begin
        if (verdict) good_q <= sat_inc(good_q);
        else         drop_q <= sat_inc(drop_q);
      end
    end

    assign good_cnt[g*C_CNTW +: C_CNTW] = good_q;
    assign drop_cnt[g*C_CNTW +: C_CNTW] = drop_q;
  end

endmodule

// File: tb/tb_ifm_out_arb.sv
// Directed bench for ifm_out_arb with behavioural show-ahead upstream FIFOs
// and a write log of the shared output FIFO.
module tb_ifm_out_arb;
  import ifm_pkg::*;

  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int CNTW = 4;
  localparam int WW   = DW + 1;

  logic                 sys_clk = 1'b0;
  logic                 rx_reset = 1'b1;
  logic [NCH*WW-1:0]    data_fifo_rdata = '0;
  logic [NCH-1:0]       data_fifo_rden;
  logic [NCH-1:0]       info_fifo_rdata = '0;
  logic [NCH-1:0]       info_fifo_empty = '1;
  logic [NCH-1:0]       info_fifo_rden;
  logic [WW-1:0]        good_fifo_wdata;
  logic [CHW-1:0]       good_fifo_wchan;
  logic                 good_fifo_wren;
  logic                 good_fifo_afull = 1'b0;
  logic                 cnt_clr = 1'b0;
  logic [NCH*CNTW-1:0]  good_cnt;
  logic [NCH*CNTW-1:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [WW-1:0] dq [NCH][$];
  logic          iq [NCH][$];

  typedef struct {
    logic [CHW-1:0] ch;
    logic [WW-1:0]  w;
    int             cyc;
  } wr_t;
  wr_t wlog [$];
  int  info_pulses [NCH];
  int  cyc = 0;

  ifm_out_arb #(
    .C_DW   (DW),
    .C_NCH  (NCH),
    .C_CHW  (CHW),
    .C_CNTW (CNTW)
  ) dut (
    .sys_clk         (sys_clk),
    .rx_reset        (rx_reset),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_rden  (data_fifo_rden),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rden  (info_fifo_rden),
    .good_fifo_wdata (good_fifo_wdata),
    .good_fifo_wchan (good_fifo_wchan),
    .good_fifo_wren  (good_fifo_wren),
    .good_fifo_afull (good_fifo_afull),
    .cnt_clr         (cnt_clr),
    .good_cnt        (good_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    for (int i = 0; i < NCH; i++) info_pulses[i] = 0;
  end

  // Upstream FIFOs and output-FIFO write log; flushed by the same reset.
  always @(posedge sys_clk or posedge rx_reset) begin
    if (rx_reset) begin
      for (int i = 0; i < NCH; i++) begin
        dq[i].delete();
        iq[i].delete();
      end
      data_fifo_rdata <= '0;
      info_fifo_rdata <= '0;
      info_fifo_empty <= '1;
    end else begin
      cyc <= cyc + 1;
      if (good_fifo_wren) wlog.push_back('{good_fifo_wchan, good_fifo_wdata, cyc});
      for (int i = 0; i < NCH; i++) begin
        if (data_fifo_rden[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        if (info_fifo_rden[i] && iq[i].size() > 0) begin
          void'(iq[i].pop_front());
          info_pulses[i] <= info_pulses[i] + 1;
        end
        data_fifo_rdata[i*WW +: WW] <= (dq[i].size() > 0) ? dq[i][0] : '0;
        info_fifo_rdata[i]          <= (iq[i].size() > 0) ? iq[i][0] : 1'b0;
        info_fifo_empty[i]          <= (iq[i].size() == 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic logic [WW-1:0] mkw(input logic eof, input logic [DW-1:0] d);
    return {eof, d};
  endfunction

  function automatic logic [CNTW-1:0] gcnt(input int ch);
    return good_cnt[ch*CNTW +: CNTW];
  endfunction

  function automatic logic [CNTW-1:0] dcnt(input int ch);
    return drop_cnt[ch*CNTW +: CNTW];
  endfunction

  function automatic bit fifos_empty();
    for (int i = 0; i < NCH; i++)
      if (dq[i].size() != 0 || iq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_frame(input int ch, input logic good, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) dq[ch].push_back(mkw(k == n - 1, base + DW'(k)));
    iq[ch].push_back(good);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    tick(1);
    while (n < budget && !fifos_empty()) begin
      tick(1);
      n++;
    end
    if (n >= budget) check("drain_timeout", 64'd1, 64'd0);
    tick(2);
  endtask

  task automatic wait_log(input int cnt, input int budget);
    int n = 0;
    while (n < budget && wlog.size() < cnt) begin
      tick(1);
      n++;
    end
    if (n >= budget) check("wait_log_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_wren"},  good_fifo_wren, 0);
    check({pfx, "_wdata"}, good_fifo_wdata, 0);
    check({pfx, "_wchan"}, good_fifo_wchan, 0);
    check({pfx, "_drden"}, data_fifo_rden, 0);
    check({pfx, "_irden"}, info_fifo_rden, 0);
    check({pfx, "_gcnt"},  good_cnt, 0);
    check({pfx, "_dcnt"},  drop_cnt, 0);
    check({pfx, "_state"}, dut.state, S_IDLE);
  endtask

  initial begin
    int lb;
    int p;
    int n;
    int s;
    int gaps;
    int gapv;
    int chs [3];
    int ch;
    int f;
    chs[0] = 0; chs[1] = 1; chs[2] = 3;

    // reset state
    tick(3);
    rx_reset = 1'b0;
    tick(2);
    check_outputs_zero("rst");

    // single channel, 4-word good frame
    lb = wlog.size();
    p  = info_pulses[0];
    push_frame(0, 1'b1, 4, 8'h10);
    drain(100);
    check("t1_nwr", wlog.size() - lb, 4);
    for (int k = 0; k < 4; k++) begin
      if (lb + k < wlog.size()) begin
        check($sformatf("t1_w%0d", k), wlog[lb+k].w, mkw(k == 3, 8'h10 + 8'(k)));
        check($sformatf("t1_c%0d", k), wlog[lb+k].ch, 0);
      end
    end
    check("t1_info", info_pulses[0] - p, 1);
    check("t1_gcnt", gcnt(0), 1);
    check("t1_dcnt", dcnt(0), 0);

    // channel 2: 1-word bad, 1-word good, then a 2-word good frame
    lb = wlog.size();
    p  = info_pulses[2];
    push_frame(2, 1'b0, 1, 8'h20);
    push_frame(2, 1'b1, 1, 8'h21);
    push_frame(2, 1'b1, 2, 8'h22);
    drain(100);
    check("t2_nwr", wlog.size() - lb, 3);
    if (lb + 2 < wlog.size()) begin
      check("t2_w0", wlog[lb].w,   9'h121);
      check("t2_w1", wlog[lb+1].w, 9'h022);
      check("t2_w2", wlog[lb+2].w, 9'h123);
      check("t2_c0", wlog[lb].ch, 2);
    end
    check("t2_dcnt", dcnt(2), 1);
    check("t2_gcnt", gcnt(2), 2);
    check("t2_info", info_pulses[2] - p, 3);

    // round-robin over channels 0,1,3 with two frames each, from ptr = 0
    rx_reset = 1'b1;
    tick(2);
    rx_reset = 1'b0;
    tick(1);
    lb = wlog.size();
    for (int fr = 0; fr < 2; fr++)
      for (int j = 0; j < 3; j++)
        push_frame(chs[j], 1'b1, 2, 8'(chs[j]*16 + fr*4));
    drain(200);
    check("t3_nwr", wlog.size() - lb, 12);
    for (int j = 0; j < 6; j++) begin
      ch = chs[j % 3];
      f  = j / 3;
      for (int w = 0; w < 2; w++) begin
        if (lb + j*2 + w < wlog.size()) begin
          check($sformatf("t3_c%0d_%0d", j, w), wlog[lb+j*2+w].ch, ch);
          check($sformatf("t3_w%0d_%0d", j, w), wlog[lb+j*2+w].w,
                mkw(w == 1, 8'(ch*16 + f*4 + w)));
        end
      end
    end

    // afull held 5 cycles in the middle of a 10-word good frame
    lb = wlog.size();
    push_frame(1, 1'b1, 10, 8'h40);
    wait_log(lb + 4, 100);
    good_fifo_afull = 1'b1;
    tick(5);
    good_fifo_afull = 1'b0;
    drain(100);
    check("t4_nwr", wlog.size() - lb, 10);
    gaps = 0;
    gapv = 0;
    for (int k = 0; k < 10; k++) begin
      if (lb + k < wlog.size()) begin
        check($sformatf("t4_w%0d", k), wlog[lb+k].w, mkw(k == 9, 8'h40 + 8'(k)));
        if (k > 0 && wlog[lb+k].cyc - wlog[lb+k-1].cyc != 1) begin
          gaps++;
          gapv = wlog[lb+k].cyc - wlog[lb+k-1].cyc;
        end
      end
    end
    check("t4_ngaps", gaps, 1);
    check("t4_gaplen", gapv, 6);

    // a dropped frame keeps draining at one word per cycle under afull
    lb = wlog.size();
    push_frame(3, 1'b0, 6, 8'h50);
    n = 0;
    tick(1);
    while (n < 50 && dq[3].size() == 6) begin
      tick(1);
      n++;
    end
    if (n >= 50) check("t5_start_timeout", 64'd1, 64'd0);
    s = dq[3].size();
    check("t5_s", s, 5);
    good_fifo_afull = 1'b1;
    tick(s - 1);
    check("t5_q1", dq[3].size(), 1);
    tick(1);
    check("t5_q0", dq[3].size(), 0);
    good_fifo_afull = 1'b0;
    drain(50);
    check("t5_nwr", wlog.size() - lb, 0);
    check("t5_dcnt", dcnt(3), 1);

    // saturation: 15 drops reach the top, a 16th stays there
    for (int k = 0; k < 15; k++) push_frame(2, 1'b0, 1, 8'h60 + 8'(k));
    drain(300);
    check("t6_dcnt15", dcnt(2), 15);
    push_frame(2, 1'b0, 1, 8'h6f);
    drain(50);
    check("t6_dcnt_sat", dcnt(2), 15);

    // clear coinciding with the EOF pop wins
    lb = wlog.size();
    push_frame(0, 1'b1, 1, 8'h70);
    n = 0;
    while (n < 50 && data_fifo_rden[0] !== 1'b1) begin
      tick(1);
      n++;
    end
    if (n >= 50) check("t7_rden_timeout", 64'd1, 64'd0);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    drain(50);
    check("t7_gcnt", gcnt(0), 0);
    check("t7_dcnt2", dcnt(2), 0);
    check("t7_nwr", wlog.size() - lb, 1);
    if (lb < wlog.size()) check("t7_w", wlog[lb].w, 9'h170);
    push_frame(0, 1'b1, 1, 8'h71);
    drain(50);
    check("t7_gcnt_after", gcnt(0), 1);

    // reset in the middle of a 6-word frame
    lb = wlog.size();
    push_frame(1, 1'b1, 6, 8'h80);
    wait_log(lb + 2, 100);
    rx_reset = 1'b1;
    #1;
    check_outputs_zero("t8_rst");
    tick(2);
    rx_reset = 1'b0;
    tick(1);
    lb = wlog.size();
    push_frame(1, 1'b1, 3, 8'h90);
    drain(100);
    check("t8_nwr", wlog.size() - lb, 3);
    for (int k = 0; k < 3; k++) begin
      if (lb + k < wlog.size()) begin
        check($sformatf("t8_w%0d", k), wlog[lb+k].w, mkw(k == 2, 8'h90 + 8'(k)));
        check($sformatf("t8_c%0d", k), wlog[lb+k].ch, 1);
      end
    end
    check("t8_gcnt", gcnt(1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifm_out_arb.md
# ifm_out_arb

Multi-channel successor to the single-channel receive output FSM. Each of C_NCH receive channels supplies a show-ahead data FIFO and a one-bit-per-frame info FIFO (good/bad verdict). The block round-robin arbitrates whole frames from these channels into one shared good-frame FIFO and discards bad frames. It also throttles on good_fifo_afull mid-frame, handles single-word frames, tags every word with its source channel, and keeps per-channel good/drop counters.

## Interface
- C_DW, 72: payload width per word, excluding the EOF flag.
- C_NCH, 4: number of input channels, 1..16.
- C_CHW, 2: channel-index width, equal to max(1, clog2(C_NCH)).
- C_CNTW, 32: width of each frame counter.

- sys_clk  in  1  clock.
- rx_reset  in  1  reset; asynchronous, active-high.
- data_fifo_rdata  in  C_NCH*(C_DW+1)  per-channel head word. Channel i occupies slice [i*(C_DW+1) +: C_DW+1]. Bit C_DW of each slice is EOF.
- data_fifo_rden  out  C_NCH  per-channel pop. Combinational.
- info_fifo_rdata  in  C_NCH  per-channel head verdict: 1 = good, 0 = drop.
- info_fifo_empty  in  C_NCH  per-channel info FIFO empty.
- info_fifo_rden  out  C_NCH  per-channel info pop. Registered.
- good_fifo_wdata  out  C_DW+1  forwarded word, with EOF in bit C_DW. Registered.
- good_fifo_wchan  out  C_CHW  source channel of good_fifo_wdata. Registered.
- good_fifo_wren  out  1  write strobe. Registered.
- good_fifo_afull  in  1  output FIFO almost full.
- cnt_clr  in  1  synchronous clear of all counters.
- good_cnt  out  C_NCH*C_CNTW  forwarded-frame count per channel.
- drop_cnt  out  C_NCH*C_CNTW  dropped-frame count per channel.

## Operation
- Precondition: a channel's info entry is written only after the channel's complete frame is in its data FIFO. While the block is reading a frame, the data FIFO head is therefore always valid.
- A channel is eligible when info_fifo_empty[i] = 0.
- **Arbitration:** round-robin. The block grants the lowest eligible index at or after the pointer ptr, wrapping around. On a grant, ptr becomes the granted index + 1, modulo C_NCH. The granted index is latched in cur and held until the frame completes.
- **States:** IDLE, FWD, DROP, EOF.
- **IDLE:**
  - Start condition: some channel is eligible and good_fifo_afull = 0.
  - On start, pop the first word of the granted channel.
  - If its EOF bit = 1, go to EOF.
  - Otherwise go to FWD if the verdict is good, or to DROP if it is bad.
  - If the verdict is good, the first word is written to the output FIFO.
- **FWD:** data_fifo_rden[cur] = !good_fifo_afull, and a write follows each pop. When a popped word has EOF = 1, go to EOF. While afull = 1, there is no pop, no write and no state change.
- **DROP:** data_fifo_rden[cur] = 1 every cycle, with afull ignored. No write. When EOF = 1, go to EOF.
- **EOF:** one cycle, then go to IDLE. This cycle lets the info FIFO head update before the next arbitration.
- **info_fifo_rden[cur]:** registered pulse, asserted in the cycle after the EOF word is popped, i.e. during the EOF state.
- **Counters:**
  - On the EOF-word pop, good_cnt[cur] or drop_cnt[cur] increments by 1 according to the verdict.
  - Counters saturate at 2^C_CNTW−1 and do not wrap.
  - cnt_clr has priority over a same-cycle increment: that count is lost.
- The verdict is sampled only at grant and latched for the whole frame.

## Timing
- Reset values: state = IDLE, ptr = 0, cur = 0, and every output, register and counter = 0.
- data_fifo_rden is combinational from state, cur, eligibility and afull.
- good_fifo_wdata, good_fifo_wchan and good_fifo_wren appear 1 cycle after the corresponding pop.
- Throughput:
  - A good frame of N words takes N+1 cycles when not throttled (N pop cycles + EOF).
  - A dropped frame also takes N+1 cycles.
  - A new grant can occur in the cycle after EOF.
- afull is sampled combinationally. The output FIFO must tolerate 1 write in flight after afull rises; the afull threshold must be at least 1.
- Reset asserted mid-frame: return to IDLE immediately and clear all state. Upstream FIFOs must also be flushed by the same reset.

## Structure
- Package ifm_pkg holds:
  - state encodings S_IDLE = 0, S_FWD = 1, S_DROP = 2, S_EOF = 3;
  - the EOF bit position convention;
  - the default C_CNTW.
- Sub-module ifm_rr_arb: a parameterised round-robin arbiter with inputs req[C_NCH], ptr and a grant enable, and outputs gnt_idx and gnt_valid. It is combinational; the pointer register lives in the parent.
- Per-channel saturating counters are built in a generate loop in the parent.

## Test plan
- **Single channel, good 4-word frame:** 4 words written with wchan = 0 and EOF only on word 4. info_fifo_rden pulses once. good_cnt[0] = 1.
- **Single-word bad frame, then single-word good frame on channel 2:** first frame produces no write and drop_cnt[2] = 1. Second frame produces exactly 1 write with EOF = 1. Neither frame consumes a word belonging to a later frame.
- **Channels 0, 1 and 3 each hold 2 frames:** grant order is 0, 1, 3, 0, 1, 3. No words from different frames are interleaved.
- **good_fifo_afull held for 5 cycles mid-way through a 10-word good frame:** the output shows a 5-cycle write gap with no lost or duplicated words. A DROP frame under afull still drains at 1 word per cycle.
- **Counter edge cases:** with drop_cnt preloaded to 2^32−1, a further drop leaves it at 2^32−1. cnt_clr asserted in the same cycle as an EOF pop leaves the counter at 0.
- **rx_reset asserted at word 3 of a 6-word frame:** all outputs are 0 and state is IDLE on the next edge. After reset is released with fresh FIFO contents, a normal frame follows.
